// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32K x 8 asynchronous SRAM controller.
package sram_ctrl_pkg;

   localparam int SRAM_ADDR_W    = 15;
   localparam int SRAM_DATA_W    = 8;
   localparam int BYTES_PER_WORD = 4;
   localparam int WAIT_CNT_W     = 3;
   localparam int WORD_W         = SRAM_DATA_W * BYTES_PER_WORD;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   typedef logic [$clog2(BYTES_PER_WORD)-1:0] byte_idx_t;

   // Little-endian byte lane k of a bus word.
   function automatic logic [SRAM_DATA_W-1:0] byte_lane(input logic [WORD_W-1:0] word,
                                                        input byte_idx_t         k);
      return word[{k, 3'b000} +: SRAM_DATA_W];
   endfunction

endpackage

// File: rtl/sram_ctrl_iobuf.sv
// Tri-state driver for the SRAM data bus; enable and data are both registered.
module sram_ctrl_iobuf
   import sram_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   drive_d,
   input  logic [SRAM_DATA_W-1:0] dout_d,
   output logic [SRAM_DATA_W-1:0] din,
   inout  wire  [SRAM_DATA_W-1:0] io
);

   logic                   oe_q;
   logic [SRAM_DATA_W-1:0] dout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oe_q   <= 1'b0;
         dout_q <= '0;
      end else begin
         oe_q   <= drive_d;
         dout_q <= dout_d;
      end
   end

   assign io  = oe_q ? dout_q : 'z;
   assign din = io;

endmodule

// File: rtl/sram_ctrl.sv
// Word-to-byte sequencer for the HM62256B-class SRAM: four little-endian byte accesses per request.
// Optional `SRAM_CTRL_ALIGN_CHECK_EN rejects requests with req_addr[1:0] != 0 via rsp_err.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W = 15,
   parameter int WAIT   = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [WORD_W-1:0]      req_wdata,
   input  logic [3:0]             req_strb,
   output logic                   rsp_valid,
   output logic [WORD_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   output logic [SRAM_ADDR_W-1:0] sram_a,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n,
   output logic                   sram_we_n,
   inout  wire  [SRAM_DATA_W-1:0] sram_io
);

   state_t                 state_q, state_d;
   byte_idx_t              byte_q, byte_d;
   logic [WAIT_CNT_W-1:0]  wait_q, wait_d;
   logic [WORD_W-1:0]      rdata_q, rdata_d;

   logic                   we_q;
   logic [ADDR_W-3:0]      addr_hi_q;
   logic [WORD_W-1:0]      wdata_q;
   logic [3:0]             strb_q;

   logic                   accept, load, misaligned;
   logic                   cur_we;
   logic [ADDR_W-3:0]      cur_hi;
   logic [WORD_W-1:0]      cur_wdata;
   logic [3:0]             cur_strb;

   logic                   rsp_valid_d, rsp_err_d;
   logic [WORD_W-1:0]      rsp_rdata_d;
   logic [SRAM_ADDR_W-1:0] a_d;
   logic                   ce_n_d, oe_n_d, we_n_d, drive_d;
   logic [SRAM_DATA_W-1:0] dout_d, din;

`ifdef SRAM_CTRL_ALIGN_CHECK_EN
   assign misaligned = (req_addr[1:0] != 2'b00);
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^req_addr[1:0];
   assign misaligned      = 1'b0;
`endif

   // NOTE: every variable in this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      byte_d      = byte_q;
      wait_d      = wait_q;
      rdata_d     = rdata_q;
      accept      = 1'b0;
      load        = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;

      unique case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept  = 1'b1;
               byte_d  = '0;
               wait_d  = '0;
               rdata_d = '0;
               if (misaligned) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d = ACCESS;
                  load    = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (wait_q == WAIT_CNT_W'(WAIT)) begin
               if (!we_q) rdata_d[{byte_q, 3'b000} +: SRAM_DATA_W] = din;
               if (byte_q == byte_idx_t'(BYTES_PER_WORD - 1)) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = we_q ? '0 : rdata_d;
               end else begin
                  byte_d = byte_q + byte_idx_t'(1);
                  wait_d = '0;
                  load   = 1'b1;
               end
            end else begin
               wait_d = wait_q + WAIT_CNT_W'(1);
               load   = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Byte-0 pins come straight from the request on the accept edge; later bytes use the latch.
      cur_we    = accept ? req_we               : we_q;
      cur_hi    = accept ? req_addr[ADDR_W-1:2] : addr_hi_q;
      cur_wdata = accept ? req_wdata            : wdata_q;
      cur_strb  = accept ? req_strb             : strb_q;

      a_d     = load ? SRAM_ADDR_W'({cur_hi, byte_d}) : sram_a;
      ce_n_d  = ~load;
      oe_n_d  = ~(load & ~cur_we);
      we_n_d  = ~(load & cur_we & cur_strb[byte_d]);
      drive_d = ~we_n_d;
      dout_d  = byte_lane(cur_wdata, byte_d);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         byte_q    <= '0;
         wait_q    <= '0;
         rdata_q   <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         sram_a    <= '0;
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
      end else begin
         state_q   <= state_d;
         byte_q    <= byte_d;
         wait_q    <= wait_d;
         rdata_q   <= rdata_d;
         req_ready <= (state_d == IDLE);
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
         sram_a    <= a_d;
         sram_ce_n <= ce_n_d;
         sram_oe_n <= oe_n_d;
         sram_we_n <= we_n_d;
      end
   end

   // NOTE: the request latch is pure datapath, only consumed after accept, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q      <= req_we;
         addr_hi_q <= req_addr[ADDR_W-1:2];
         wdata_q   <= req_wdata;
         strb_q    <= req_strb;
      end
   end

   sram_ctrl_iobuf u_iobuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .drive_d (drive_d),
      .dout_d  (dout_d),
      .din     (din),
      .io      (sram_io)
   );

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: WAIT=0 and WAIT=2 instances share one request stream, each with its own SRAM model.
module tb_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [14:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_strb = '0;

   logic        rdy0, rv0, err0, ce0, oe0, we0;
   logic [31:0] rd0;
   logic [14:0] a0;
   wire  [7:0]  io0;
   logic        rdy2, rv2, err2, ce2, oe2, we2;
   logic [31:0] rd2;
   logic [14:0] a2;
   wire  [7:0]  io2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sram_ctrl #(.ADDR_W(15), .WAIT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .rsp_valid(rv0),
      .rsp_rdata(rd0), .rsp_err(err0), .sram_a(a0), .sram_ce_n(ce0), .sram_oe_n(oe0),
      .sram_we_n(we0), .sram_io(io0)
   );

   sram_ctrl #(.ADDR_W(15), .WAIT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .rsp_valid(rv2),
      .rsp_rdata(rd2), .rsp_err(err2), .sram_a(a2), .sram_ce_n(ce2), .sram_oe_n(oe2),
      .sram_we_n(we2), .sram_io(io2)
   );

   // SRAM models: write on posedge while ce_n/we_n low, drive io while ce_n/oe_n low.
   logic [7:0]  mem0 [0:32767];
   logic [7:0]  mem2 [0:32767];
   logic        pl_en = 1'b0;
   logic [14:0] pl_a = '0;
   logic [7:0]  pl_d = '0;

   always @(posedge clk) begin
      if (pl_en) begin
         mem0[pl_a] <= pl_d;
         mem2[pl_a] <= pl_d;
      end else begin
         if (!ce0 && !we0) mem0[a0] <= io0;
         if (!ce2 && !we2) mem2[a2] <= io2;
      end
   end

   assign io0 = (!ce0 && !oe0) ? mem0[a0] : 8'bz;
   assign io2 = (!ce2 && !oe2) ? mem2[a2] : 8'bz;

   int ovl_cnt = 0;
   int drv_cnt = 0;
   always @(negedge clk) begin
      if ((!oe0 && !we0) || (!oe2 && !we2)) ovl_cnt <= ovl_cnt + 1;
      if ((dut0.u_iobuf.oe_q && we0) || (dut2.u_iobuf.oe_q && we2)) drv_cnt <= drv_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [14:0] addr, input logic [7:0] d);
      pl_en = 1'b1;
      pl_a  = addr;
      pl_d  = d;
      tick();
      pl_en = 1'b0;
   endtask

   function automatic logic [31:0] memw0(input int a);
      return {mem0[a+3], mem0[a+2], mem0[a+1], mem0[a]};
   endfunction

   function automatic logic [31:0] memw2(input int a);
      return {mem2[a+3], mem2[a+2], mem2[a+1], mem2[a]};
   endfunction

   task automatic wait_ready();
      int g = 0;
      while (!(rdy0 && rdy2) && g < 100) begin
         tick();
         g++;
      end
      check("ready_wait", {31'd0, rdy0 & rdy2}, 32'd1);
   endtask

   // Results of the latest transaction; latency counts edges after the accept edge.
   int          lat0, lat2;
   logic [31:0] r0, r2;
   logic        e0, e2;
   logic [3:0]  wetr0;
   logic [14:0] atr2 [0:11];

   task automatic xact(input logic we, input logic [14:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb);
      int n = 0;
      wait_ready();
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      req_strb  = strb;
      tick();
      req_valid = 1'b0;
      lat0 = -1;
      lat2 = -1;
      wetr0 = '1;
      while ((lat0 < 0 || lat2 < 0) && n < 40) begin
         if (n < 4)  wetr0[n] = we0;
         if (n < 12) atr2[n] = a2;
         if (rv0 && lat0 < 0) begin lat0 = n; r0 = rd0; e0 = err0; end
         if (rv2 && lat2 < 0) begin lat2 = n; r2 = rd2; e2 = err2; end
         if (lat0 < 0 || lat2 < 0) begin
            tick();
            n++;
         end
      end
      tick();
   endtask

   initial begin
      logic [6:0] rdy_mask, rdy2_mask, rv_mask;
      logic       rv_seen;

      // Reset state
      repeat (2) tick();
      check("rst_ready", {31'd0, rdy0}, 32'd0);
      check("rst_rsp", {29'd0, rv0, err0, rv2}, 32'd0);
      check("rst_ctrl", {29'd0, ce0, oe0, we0}, 32'd7);
      check("rst_addr", {17'd0, a0}, 32'd0);
      check("rst_rdata", rd0, 32'd0);
      check("rst_io_drive", {31'd0, dut0.u_iobuf.oe_q}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("ready_after_rst", {30'd0, rdy0, rdy2}, 32'd3);

      preload(15'h7FFC, 8'hAA);
      preload(15'h7FFD, 8'hBB);
      preload(15'h7FFE, 8'hCC);
      preload(15'h7FFF, 8'hDD);

      // Full word write
      xact(1'b1, 15'h0010, 32'hDEADBEEF, 4'hF);
      check("wr_lat0", lat0, 32'd4);
      check("wr_lat2", lat2, 32'd12);
      check("wr_rdata", r0, 32'd0);
      check("wr_err", {31'd0, e0}, 32'd0);
      check("wr_mem0", memw0(16), 32'hDEADBEEF);
      check("wr_mem2", memw2(16), 32'hDEADBEEF);
      check("wr_we_trace", {28'd0, wetr0}, 32'h0);

      // Read back
      xact(1'b0, 15'h0010, 32'h0, 4'h0);
      check("rd_lat0", lat0, 32'd4);
      check("rd_data0", r0, 32'hDEADBEEF);
      check("rd_data2", r2, 32'hDEADBEEF);

      // Partial strobe write, bytes 0 and 2 only
      xact(1'b1, 15'h0010, 32'h11223344, 4'h5);
      check("strb_we_trace", {28'd0, wetr0}, 32'hA);
      check("strb_mem0", memw0(16), 32'hDE22BE44);
      xact(1'b0, 15'h0010, 32'h0, 4'h0);
      check("strb_rd0", r0, 32'hDE22BE44);
      check("strb_rd2", r2, 32'hDE22BE44);

      // Top word, WAIT=2 timing and address hold
      xact(1'b0, 15'h7FFC, 32'h0, 4'h0);
      check("top_rd2", r2, 32'hDDCCBBAA);
      check("top_lat2", lat2, 32'd12);
      check("top_rd0", r0, 32'hDDCCBBAA);
      for (int k = 0; k < 12; k++)
         check($sformatf("top_addr_hold_%0d", k), {17'd0, atr2[k]}, 32'h7FFC + k / 3);

      // Back-to-back with req_valid held high
      wait_ready();
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 15'h0010;
      tick();
      for (int k = 0; k < 7; k++) begin
         rdy_mask[k]  = rdy0;
         rdy2_mask[k] = rdy2;
         rv_mask[k]   = rv0;
         if (k < 6) tick();
      end
      req_valid = 1'b0;
      check("b2b_ready0", {25'd0, rdy_mask}, 32'b0100000);
      check("b2b_rsp0", {25'd0, rv_mask}, 32'b0010000);
      check("b2b_ready2", {25'd0, rdy2_mask}, 32'd0);
      wait_ready();

      // Misaligned request
      xact(1'b1, 15'h0011, 32'hFFFFFFFF, 4'hF);
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
      check("mis_lat0", lat0, 32'd0);
      check("mis_err0", {31'd0, e0}, 32'd1);
      check("mis_rdata0", r0, 32'd0);
      check("mis_err2", {31'd0, e2}, 32'd1);
      check("mis_mem0", memw0(16), 32'hDE22BE44);
      check("mis_we_trace", {28'd0, wetr0}, 32'hF);
`else
      check("mis_lat0", lat0, 32'd4);
      check("mis_err0", {31'd0, e0}, 32'd0);
      check("mis_mem0", memw0(16), 32'hFFFFFFFF);
      check("mis_mem2", memw2(16), 32'hFFFFFFFF);
`endif

      // Reset during byte 2 of a write
      wait_ready();
      preload(15'h0020, 8'h11);
      preload(15'h0021, 8'h22);
      preload(15'h0022, 8'h33);
      preload(15'h0023, 8'h44);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 15'h0020;
      req_wdata = 32'hA5A5A5A5;
      req_strb  = 4'hF;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      check("rstmid_byte2_addr", {17'd0, a0}, 32'h22);
      check("rstmid_byte2_we", {31'd0, we0}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("rstmid_ctrl", {29'd0, ce0, oe0, we0}, 32'd7);
      check("rstmid_io", {31'd0, dut0.u_iobuf.oe_q}, 32'd0);
      rv_seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         rv_seen = rv_seen | rv0 | rv2;
      end
      rst_n = 1'b1;
      tick();
      rv_seen = rv_seen | rv0;
      check("rstmid_ready", {31'd0, rdy0}, 32'd1);
      check("rstmid_no_rsp", {31'd0, rv_seen}, 32'd0);
      check("rstmid_mem", memw0(32), 32'h4433A5A5);

      check("oe_we_overlap", ovl_cnt, 32'd0);
      check("io_drive_we_high", drv_cnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
